// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide controller.
package muldiv_pkg;

    // Operation codes presented on op by the decoder.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Divider iterations: one quotient bit per cycle across the datapath width.
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step.
// The quotient register starts holding the dividend and shifts quotient bits in
// from the right, so after DIV_ITER steps it holds the full quotient.
module div_core
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next
);

    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [32:0] partial_s;
    logic [32:0] diff_s;

    // Combinational shift-subtract step; outputs are the post-step values so the
    // controller can commit the final step without an extra cycle.
    always_comb begin
        partial_s = {rem_r, quo_r[31]};
        diff_s    = partial_s - {1'b0, dvs_r};
        // partial < 2*divisor, so bit 32 of the difference is set exactly on borrow.
        if (diff_s[32] == 1'b0) begin
            rem_next = diff_s[31:0];
            quo_next = {quo_r[30:0], 1'b1};
        end else begin
            rem_next = partial_s[31:0];
            quo_next = {quo_r[30:0], 1'b0};
        end
    end

    // Divider state: load operands, or advance one step when enabled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_r <= 32'd0;
            rem_r <= 32'd0;
            dvs_r <= 32'd0;
        end else if (load) begin
            quo_r <= dividend;
            rem_r <= 32'd0;
            dvs_r <= divisor;
        end else if (step) begin
            quo_r <= quo_next;
            rem_r <= rem_next;
        end else begin
            quo_r <= quo_r;
            rem_r <= rem_r;
            dvs_r <= dvs_r;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and HI/LO register owner.
// Drives the external pipelined multiplier, runs the internal divider, stalls the
// pipeline while an operation is in flight and commits 64-bit results to HI/LO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic             q_neg_r, q_neg_s;
    logic             r_neg_r, r_neg_s;
    logic             mul_sgn_r, mul_sgn_s;
    logic             div_sgn_s;
    logic             div_load_s;
    logic             div_step_s;
    logic [31:0]      div_a_s;
    logic [31:0]      div_b_s;
    logic [31:0]      quo_next_s;
    logic [31:0]      rem_next_s;

    div_core u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .load     (div_load_s),
        .step     (div_step_s),
        .dividend (div_a_s),
        .divisor  (div_b_s),
        .quo_next (quo_next_s),
        .rem_next (rem_next_s)
    );

    // Next-state, datapath next values and combinational outputs.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        q_neg_s    = q_neg_r;
        r_neg_s    = r_neg_r;
        mul_sgn_s  = mul_sgn_r;
        div_sgn_s  = 1'b0;
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        div_a_s    = 32'd0;
        div_b_s    = 32'd0;
        stall_req  = 1'b0;
        mul_ina    = 32'd0;
        mul_inb    = 32'd0;
        mul_signed = 1'b0;
        done       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Nothing is accepted on a flush or while reset is asserted.
                if (op_valid && !flush && resetn) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            stall_req  = 1'b1;
                            mul_ina    = src_a;
                            mul_inb    = src_b;
                            mul_signed = (op == MD_MULT);
                            mul_sgn_s  = (op == MD_MULT);
                            cnt_s      = CNT_W'(MUL_LAT - 1);
                            state_s    = ST_MUL_WAIT;
                        end
                        MD_DIV, MD_DIVU: begin
                            stall_req = 1'b1;
                            if (src_b == 32'd0) begin
                                lo_s    = 32'hFFFF_FFFF;
                                hi_s    = src_a;
                                state_s = ST_DONE;
                            end else begin
                                div_sgn_s  = (op == MD_DIV);
                                div_load_s = 1'b1;
                                div_a_s    = cond_neg(src_a, div_sgn_s && src_a[31]);
                                div_b_s    = cond_neg(src_b, div_sgn_s && src_b[31]);
                                q_neg_s    = div_sgn_s && (src_a[31] ^ src_b[31]);
                                r_neg_s    = div_sgn_s && src_a[31];
                                cnt_s      = CNT_W'(DIV_ITER - 1);
                                state_s    = ST_DIV_BUSY;
                            end
                        end
                        MD_MTHI: begin
                            hi_s = src_a;
                        end
                        MD_MTLO: begin
                            lo_s = src_a;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL_WAIT: begin
                stall_req  = 1'b1;
                mul_ina    = src_a;
                mul_inb    = src_b;
                mul_signed = mul_sgn_r;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    {hi_s, lo_s} = mul_result;
                    state_s      = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DIV_BUSY: begin
                stall_req  = 1'b1;
                div_step_s = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    lo_s    = cond_neg(quo_next_s, q_neg_r);
                    hi_s    = cond_neg(rem_next_s, r_neg_r);
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // op_valid here is the same instruction leaving EX; never re-issue.
                done    = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Flush aborts everything in flight and suppresses any HI/LO write.
        if (flush) begin
            state_s    = ST_IDLE;
            cnt_s      = {CNT_W{1'b0}};
            hi_s       = hi_r;
            lo_s       = lo_r;
            div_step_s = 1'b0;
        end else begin
            cnt_s = cnt_s;
        end
    end

    // State and HI/LO registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            mul_sgn_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            q_neg_r   <= q_neg_s;
            r_neg_r   <= r_neg_s;
            mul_sgn_r <= mul_sgn_s;
        end
    end

    assign hi_o = hi_r;
    assign lo_o = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a 2-stage multiplier model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        stall_req;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .mul_signed (mul_signed),
        .mul_ina    (mul_ina),
        .mul_inb    (mul_inb),
        .mul_result (mul_result),
        .stall_req  (stall_req),
        .done       (done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    // External multiplier model: two register stages, result valid MUL_LAT=2 cycles later.
    logic [63:0] ext_a, ext_b;
    logic [63:0] p1 = 64'd0;
    logic [63:0] p2 = 64'd0;
    always_comb begin
        ext_a = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
        ext_b = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    end
    always @(posedge clk) begin
        p1 <= ext_a * ext_b;
        p2 <= p1;
    end
    assign mul_result = p2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count stall cycles (bounded), hold op_valid through DONE, then release.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic dn, output logic sg,
                         output logic [31:0] ia, output logic [31:0] ib);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        sg = mul_signed; ia = mul_ina; ib = mul_inb;
        stalls = 0;
        while (stall_req === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
        end
        dn = done;
        tick();
        op_valid = 1'b0; op = MD_NONE; src_a = 32'd0; src_b = 32'd0;
        #1;
    endtask

    int          st;
    logic        dn, sg;
    logic [31:0] ia, ib;

    initial begin
        resetn = 1'b0; flush = 1'b0; op_valid = 1'b0; op = MD_NONE;
        src_a = 32'd0; src_b = 32'd0;
        tick(); tick();
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_mul_ops", {mul_ina, mul_inb}, 64'd0);
        chk("rst_mul_signed", 64'(mul_signed), 64'd0);
        resetn = 1'b1;
        tick();

        // MULT -3 * 5
        do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, st, dn, sg, ia, ib);
        chk("mult_stalls", 64'(st), 64'd3);
        chk("mult_done", 64'(dn), 64'd1);
        chk("mult_signed", 64'(sg), 64'd1);
        chk("mult_ops", {ia, ib}, 64'hFFFF_FFFD_0000_0005);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mult_no_reissue_stall", 64'(stall_req), 64'd0);
        chk("mult_no_reissue_done", 64'(done), 64'd0);
        tick();
        chk("mult_single_done", 64'(done), 64'd0);

        // MULTU 0xFFFFFFFF * 2
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, st, dn, sg, ia, ib);
        chk("multu_stalls", 64'(st), 64'd3);
        chk("multu_signed", 64'(sg), 64'd0);
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

        // DIVU 100 / 7
        do_op(MD_DIVU, 32'd100, 32'd7, st, dn, sg, ia, ib);
        chk("divu_stalls", 64'(st), 64'd33);
        chk("divu_done", 64'(dn), 64'd1);
        chk("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});

        // DIV -7 / 2
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, st, dn, sg, ia, ib);
        chk("div_neg_stalls", 64'(st), 64'd33);
        chk("div_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 0x80000000 / -1
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, dn, sg, ia, ib);
        chk("div_ovf_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // DIV 5 / 0
        do_op(MD_DIV, 32'd5, 32'd0, st, dn, sg, ia, ib);
        chk("div0_stalls", 64'(st), 64'd1);
        chk("div0_done", 64'(dn), 64'd1);
        chk("div0_hilo", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);

        // MTHI then MTLO back-to-back
        op_valid = 1'b1; op = MD_MTHI; src_a = 32'h1234; #1;
        chk("mthi_stall", 64'(stall_req), 64'd0);
        tick();
        op = MD_MTLO; src_a = 32'h5678; #1;
        chk("mtlo_stall", 64'(stall_req), 64'd0);
        chk("mthi_hi", 64'(hi_o), 64'h1234);
        tick();
        op_valid = 1'b0; op = MD_NONE; src_a = 32'd0; #1;
        chk("mt_hilo", {hi_o, lo_o}, 64'h0000_1234_0000_5678);
        chk("mt_done", 64'(done), 64'd0);

        // Flush on the 10th DIV_BUSY cycle
        op_valid = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7; #1;
        tick();
        repeat (9) tick();
        chk("flush10_busy", 64'(stall_req), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; op_valid = 1'b0; op = MD_NONE; #1;
        chk("flush10_stall", 64'(stall_req), 64'd0);
        chk("flush10_done", 64'(done), 64'd0);
        chk("flush10_hilo", {hi_o, lo_o}, 64'h0000_1234_0000_5678);
        tick();
        chk("flush10_done_later", 64'(done), 64'd0);

        // Flush on the commit edge
        op_valid = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7; #1;
        tick();
        repeat (31) tick();
        chk("flushc_busy", 64'(stall_req), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; op_valid = 1'b0; op = MD_NONE; #1;
        chk("flushc_stall", 64'(stall_req), 64'd0);
        chk("flushc_done", 64'(done), 64'd0);
        chk("flushc_hilo", {hi_o, lo_o}, 64'h0000_1234_0000_5678);

        // Divider works again after aborted runs
        do_op(MD_DIVU, 32'd100, 32'd7, st, dn, sg, ia, ib);
        chk("redivu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});

        // MTHI together with flush is suppressed
        op_valid = 1'b1; op = MD_MTHI; src_a = 32'hAAAA; flush = 1'b1; #1;
        chk("flush_mthi_stall", 64'(stall_req), 64'd0);
        tick();
        flush = 1'b0; op_valid = 1'b0; op = MD_NONE; #1;
        chk("flush_mthi_hi", 64'(hi_o), 64'd2);

        // Undefined op code is ignored
        op_valid = 1'b1; op = 3'd7; src_a = 32'hFFFF; src_b = 32'd3; #1;
        chk("undef_stall", 64'(stall_req), 64'd0);
        tick();
        op_valid = 1'b0; op = MD_NONE; #1;
        chk("undef_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        chk("undef_done", 64'(done), 64'd0);

        // Reset during MUL_WAIT
        op_valid = 1'b1; op = MD_MULT; src_a = 32'd3; src_b = 32'd4; #1;
        tick();
        chk("rstmw_busy", 64'(stall_req), 64'd1);
        resetn = 1'b0; op_valid = 1'b0; op = MD_NONE;
        tick();
        resetn = 1'b1; #1;
        chk("rstmw_stall", 64'(stall_req), 64'd0);
        chk("rstmw_done", 64'(done), 64'd0);
        chk("rstmw_hilo", {hi_o, lo_o}, 64'd0);
        chk("rstmw_mul_ops", {mul_ina, mul_inb}, 64'd0);
        chk("rstmw_mul_signed", 64'(mul_signed), 64'd0);
        tick();
        chk("rstmw_done_later", 64'(done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
